mult_acc_unit: RTL and testbench
================================

Name: mult_acc_unit

Overview:
- Pipelined multiply-accumulate block: multiplies unsigned a by signed b and adds each product into a wide accumulator.
- Registered inputs, a registered product, and an accumulator register that drives p.
- A reload pulse restarts the accumulation from a configured initial value.
- Sits in the scope datapath as a running-sum engine, e.g. for correlation or filtering.
- Device-global reset (GRS) is handled at top level and is not part of this block.

Parameters:
- ASIZE, 8, width of a (2..36).
- BSIZE, 18, width of b (2..27).
- A_SIGNED, 0, 1 means a is two's complement.
- B_SIGNED, 1, 1 means b is two's complement.
- PSIZE, 96, accumulator/output width (24, 48, 66, 84 or 96).
- INREG_EN, 1, enables the input register stage on a, b and reload.
- PIPEREG_EN, 1, enables the product pipeline register stage.
- ACC_ADDSUB_OP, 0, 0 means acc += product; 1 means acc -= product.
- ACC_INIT_VALUE, PSIZE'h0, value loaded into the accumulator on reload.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset; clears every register
- ce  in  1  clock enable; when 0, all registers (including the pipeline copies of reload) hold
- a  in  ASIZE  multiplicand
- b  in  BSIZE  multiplier
- reload  in  1  when 1, restarts accumulation at ACC_INIT_VALUE
- p  out  PSIZE  accumulator value

Behaviour:
- While rst=0, all stage registers and the accumulator clear asynchronously, so p=0. Operation resumes on the first rising edge after rst returns to 1.
- Product is formed at full width ASIZE+BSIZE, honouring A_SIGNED and B_SIGNED. It is sign-extended (or zero-extended when both operands are unsigned) to PSIZE. A product with either operand 0 is exactly 0.
- Pipeline with default parameters:
  - edge k: a_r <= a, b_r <= b, rl_r <= reload
  - edge k+1: prod_r <= a_r*b_r, rl_rr <= rl_r
  - edge k+2: acc <= rl_rr ? ACC_INIT_VALUE : acc ± prod_r
- Latency: operands present before edge k affect p after edge k+2.
- Each disabled stage (INREG_EN=0 or PIPEREG_EN=0) becomes a wire and removes one cycle of latency. With both disabled, acc <= reload ? init : acc ± a*b.
- reload is delayed through exactly the same stages as the operands. The product travelling alongside reload is discarded, not added to the init value.
- Back-to-back reload cycles keep loading the init value.
- Arithmetic wraps modulo 2^PSIZE; there is no saturation and no overflow flag.
- With ce=0, p is frozen and no state advances.

Optional Feature:
- Macro MULT_ACC_DYN_ADDSUB_EN.
- When defined: adds input acc_addsub (1 bit). It is pipelined with the same latency as a and b. Per sample, 0 adds and 1 subtracts, overriding ACC_ADDSUB_OP.
- When undefined: the port is absent and ACC_ADDSUB_OP fixes the operation.

Decomposition:
- Package mult_acc_pkg holds:
  - the default width constants (ASIZE, BSIZE, PSIZE)
  - ACC_INIT_VALUE default
  - a function sext_product(a, b) returning the PSIZE-extended product
- One sub-module is natural: mult_acc_mul. It contains the optional input registers, the signed/unsigned multiplier and the optional product register, and outputs a PSIZE-wide product plus the delayed reload.

Test Plan:
- Reset: hold rst=0 with random a and b -> p=0. After release, with a=0 and b=0 -> p stays 0.
- Constant accumulate: a=3, b=5 every cycle after reset -> p follows 15, 30, 45, ..., with the first 15 appearing 3 edges after the first valid operands.
- Signed b: a=200, b=18'h3FFFF (-1) for 4 cycles -> p = -800 sign-extended (96'hFFFF...FCE0).
- Reload: accumulate to a nonzero value, pulse reload for 1 cycle while a=7, b=9 -> p becomes 0 exactly 3 edges after the pulse. That cycle's product is not included; accumulation resumes on the next edge.
- ce=0 for 5 cycles mid-stream -> p is unchanged. On ce=1, the sequence continues with no lost or duplicated samples.
- Random: 5000 random a and b with a periodic reload -> compare p against a reference running sum delayed 2 cycles, requiring a bit-exact match including 96-bit wrap.

Source files
------------

// File: rtl/mult_acc_pkg.sv
// Shared widths, defaults and the product helper for the multiply-accumulate unit.
package mult_acc_pkg;

    localparam int DEF_ASIZE = 8;
    localparam int DEF_BSIZE = 18;
    localparam int DEF_PSIZE = 96;
    localparam logic [95:0] DEF_ACC_INIT = '0;

    // Operand widths wide enough for the largest ASIZE/BSIZE plus one sign bit.
    localparam int MUL_AW = 37;
    localparam int MUL_BW = 28;

    // Callers pre-extend the operands (sign or zero), so the full signed product
    // already carries the right value; widen it to the maximum accumulator width.
    function automatic logic [95:0] sext_product(input logic signed [MUL_AW-1:0] a,
                                                 input logic signed [MUL_BW-1:0] b);
        logic signed [MUL_AW+MUL_BW-1:0] pr;
        pr = a * b;
        return {{(96-MUL_AW-MUL_BW){pr[MUL_AW+MUL_BW-1]}}, pr};
    endfunction

endpackage

// File: rtl/mult_acc_if.sv
// Operand/result bundle of the multiply-accumulate unit.
// Carries acc_addsub only when MULT_ACC_DYN_ADDSUB_EN is defined.
interface mult_acc_if
    import mult_acc_pkg::*;
#(
    parameter int ASIZE = DEF_ASIZE,
    parameter int BSIZE = DEF_BSIZE,
    parameter int PSIZE = DEF_PSIZE
);
    logic             ce;
    logic [ASIZE-1:0] a;
    logic [BSIZE-1:0] b;
    logic             reload;
`ifdef MULT_ACC_DYN_ADDSUB_EN
    logic             acc_addsub;
`endif
    logic [PSIZE-1:0] p;

`ifdef MULT_ACC_DYN_ADDSUB_EN
    modport master (output ce, a, b, reload, acc_addsub, input p);
    modport slave  (input ce, a, b, reload, acc_addsub, output p);
`else
    modport master (output ce, a, b, reload, input p);
    modport slave  (input ce, a, b, reload, output p);
`endif

endinterface

// File: rtl/mult_acc_mul.sv
// Optional input registers, signed/unsigned multiplier and optional product register.
// Reload (and acc_addsub under MULT_ACC_DYN_ADDSUB_EN) travel with the operands.
module mult_acc_mul
    import mult_acc_pkg::*;
#(
    parameter int ASIZE      = DEF_ASIZE,
    parameter int BSIZE      = DEF_BSIZE,
    parameter int PSIZE      = DEF_PSIZE,
    parameter int A_SIGNED   = 0,
    parameter int B_SIGNED   = 1,
    parameter int INREG_EN   = 1,
    parameter int PIPEREG_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [ASIZE-1:0] a,
    input  logic [BSIZE-1:0] b,
    input  logic             reload,
`ifdef MULT_ACC_DYN_ADDSUB_EN
    input  logic             acc_addsub,
    output logic             sub,
`endif
    output logic [PSIZE-1:0] prod,
    output logic             rl
);

    logic [ASIZE-1:0] a_s;
    logic [BSIZE-1:0] b_s;
    logic             rl_s;
`ifdef MULT_ACC_DYN_ADDSUB_EN
    logic             sub_s;
`endif

    generate
        if (INREG_EN != 0) begin : g_inreg
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    a_s  <= '0;
                    b_s  <= '0;
                    rl_s <= 1'b0;
`ifdef MULT_ACC_DYN_ADDSUB_EN
                    sub_s <= 1'b0;
`endif
                end else if (ce) begin
                    a_s  <= a;
                    b_s  <= b;
                    rl_s <= reload;
`ifdef MULT_ACC_DYN_ADDSUB_EN
                    sub_s <= acc_addsub;
`endif
                end
            end
        end else begin : g_inwire
            assign a_s  = a;
            assign b_s  = b;
            assign rl_s = reload;
`ifdef MULT_ACC_DYN_ADDSUB_EN
            assign sub_s = acc_addsub;
`endif
        end
    endgenerate

    // Extension choice per operand makes one signed multiplier cover all sign modes.
    logic signed [MUL_AW-1:0] a_x;
    logic signed [MUL_BW-1:0] b_x;
    logic        [95:0]       prod_full;
    logic        [PSIZE-1:0]  prod_c;

    assign a_x       = {{(MUL_AW-ASIZE){(A_SIGNED != 0) ? a_s[ASIZE-1] : 1'b0}}, a_s};
    assign b_x       = {{(MUL_BW-BSIZE){(B_SIGNED != 0) ? b_s[BSIZE-1] : 1'b0}}, b_s};
    assign prod_full = sext_product(a_x, b_x);
    assign prod_c    = prod_full[PSIZE-1:0];

    generate
        if (PIPEREG_EN != 0) begin : g_pipereg
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    prod <= '0;
                    rl   <= 1'b0;
`ifdef MULT_ACC_DYN_ADDSUB_EN
                    sub  <= 1'b0;
`endif
                end else if (ce) begin
                    prod <= prod_c;
                    rl   <= rl_s;
`ifdef MULT_ACC_DYN_ADDSUB_EN
                    sub  <= sub_s;
`endif
                end
            end
        end else begin : g_pipewire
            assign prod = prod_c;
            assign rl   = rl_s;
`ifdef MULT_ACC_DYN_ADDSUB_EN
            assign sub  = sub_s;
`endif
        end
    endgenerate

endmodule

// File: rtl/mult_acc_unit.sv
// Pipelined multiply-accumulate: p is a wrapping running sum of a*b, restarted by reload.
// Define MULT_ACC_DYN_ADDSUB_EN for a per-sample add/subtract select.
module mult_acc_unit
    import mult_acc_pkg::*;
#(
    parameter int               ASIZE          = DEF_ASIZE,
    parameter int               BSIZE          = DEF_BSIZE,
    parameter int               A_SIGNED       = 0,
    parameter int               B_SIGNED       = 1,
    parameter int               PSIZE          = DEF_PSIZE,
    parameter int               INREG_EN       = 1,
    parameter int               PIPEREG_EN     = 1,
    parameter int               ACC_ADDSUB_OP  = 0,
    parameter logic [PSIZE-1:0] ACC_INIT_VALUE = DEF_ACC_INIT[PSIZE-1:0]
) (
    input  logic     clk,
    input  logic     rst,
    mult_acc_if.slave bus
);

    logic [PSIZE-1:0] prod;
    logic [PSIZE-1:0] acc;
    logic             rl;
    logic             sub;

    mult_acc_mul #(
        .ASIZE      (ASIZE),
        .BSIZE      (BSIZE),
        .PSIZE      (PSIZE),
        .A_SIGNED   (A_SIGNED),
        .B_SIGNED   (B_SIGNED),
        .INREG_EN   (INREG_EN),
        .PIPEREG_EN (PIPEREG_EN)
    ) u_mul (
        .clk        (clk),
        .rst        (rst),
        .ce         (bus.ce),
        .a          (bus.a),
        .b          (bus.b),
        .reload     (bus.reload),
`ifdef MULT_ACC_DYN_ADDSUB_EN
        .acc_addsub (bus.acc_addsub),
        .sub        (sub),
`endif
        .prod       (prod),
        .rl         (rl)
    );

`ifndef MULT_ACC_DYN_ADDSUB_EN
    assign sub = (ACC_ADDSUB_OP != 0);
`endif

    // The product arriving with reload is dropped, not added to the init value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc <= '0;
        else if (bus.ce)
            acc <= rl ? ACC_INIT_VALUE : (sub ? acc - prod : acc + prod);
    end

    assign bus.p = acc;

endmodule

// File: tb/tb_mult_acc_unit.sv
// Directed vector table plus a randomized running-sum scoreboard for mult_acc_unit.
module tb_mult_acc_unit;

    typedef struct {
        logic        ce;
        logic [7:0]  a;
        logic [17:0] b;
        logic        reload;
        logic [95:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mult_acc_if bus ();

    mult_acc_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic ce, input logic [7:0] a, input logic [17:0] b,
                                input logic rl, input logic [95:0] exp);
        vec_t v;
        v.ce = ce; v.a = a; v.b = b; v.reload = rl; v.exp = exp;
        return v;
    endfunction

    function automatic logic [95:0] neg(input logic [95:0] n);
        return 96'd0 - n;
    endfunction

    function automatic logic [95:0] ref_prod(input logic [7:0] a, input logic [17:0] b);
        logic signed [95:0] pr;
        pr = $signed({88'd0, a}) * $signed({{78{b[17]}}, b});
        return pr;
    endfunction

    vec_t vt[33];
    localparam logic [17:0] M1 = 18'h3FFFF;

    logic        q_rl[$];
    logic [95:0] q_pr[$];
    logic [95:0] acc_m;
    logic        f_rl;
    logic [95:0] f_pr;

    initial begin
        // After reset: zeros, then 3*5 accumulation with a reload pulse carrying 7*9.
        vt[0]  = mk(1, 0,   0,  0, 96'd0);
        vt[1]  = mk(1, 0,   0,  0, 96'd0);
        vt[2]  = mk(1, 0,   0,  0, 96'd0);
        vt[3]  = mk(1, 3,   5,  0, 96'd0);
        vt[4]  = mk(1, 3,   5,  0, 96'd0);
        vt[5]  = mk(1, 3,   5,  0, 96'd15);
        vt[6]  = mk(1, 3,   5,  0, 96'd30);
        vt[7]  = mk(1, 7,   9,  1, 96'd45);
        vt[8]  = mk(1, 200, M1, 0, 96'd60);
        vt[9]  = mk(1, 200, M1, 0, 96'd0);
        vt[10] = mk(1, 200, M1, 0, neg(200));
        vt[11] = mk(1, 200, M1, 0, neg(400));
        vt[12] = mk(1, 0,   0,  0, neg(600));
        vt[13] = mk(1, 0,   0,  0, neg(800));
        vt[14] = mk(1, 0,   0,  0, neg(800));
        // ce low for 5 cycles: inputs ignored, p frozen, pipeline resumes intact.
        vt[15] = mk(1, 1,   1,  0, neg(800));
        vt[16] = mk(1, 2,   1,  0, neg(800));
        vt[17] = mk(0, 4,   1,  0, neg(800));
        vt[18] = mk(0, 4,   1,  0, neg(800));
        vt[19] = mk(0, 4,   1,  0, neg(800));
        vt[20] = mk(0, 4,   1,  0, neg(800));
        vt[21] = mk(0, 4,   1,  0, neg(800));
        vt[22] = mk(1, 4,   1,  0, neg(799));
        vt[23] = mk(1, 8,   1,  0, neg(797));
        vt[24] = mk(1, 0,   0,  0, neg(793));
        vt[25] = mk(1, 0,   0,  0, neg(785));
        vt[26] = mk(1, 0,   0,  0, neg(785));
        // Back-to-back reloads with nonzero products alongside.
        vt[27] = mk(1, 6,   6,  1, neg(785));
        vt[28] = mk(1, 6,   6,  1, neg(785));
        vt[29] = mk(1, 5,   5,  0, 96'd0);
        vt[30] = mk(1, 0,   0,  0, 96'd0);
        vt[31] = mk(1, 0,   0,  0, 96'd25);
        vt[32] = mk(1, 0,   0,  0, 96'd25);

`ifdef MULT_ACC_DYN_ADDSUB_EN
        bus.acc_addsub = 1'b0;
`endif
        bus.ce     = 1'b1;
        bus.reload = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.a = 8'($urandom);
            bus.b = 18'($urandom);
            bus.reload = 1'($urandom);
            @(posedge clk); #1;
            chk("reset_hold", bus.p, 96'd0);
        end
        bus.a = '0; bus.b = '0; bus.reload = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 33; i++) begin
            bus.ce = vt[i].ce; bus.a = vt[i].a; bus.b = vt[i].b; bus.reload = vt[i].reload;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), bus.p, vt[i].exp);
        end

        // Scoreboard: two in-flight samples, each applied two ce-cycles later.
        acc_m = 96'd25;
        q_rl.push_back(1'b0); q_pr.push_back(96'd0);
        q_rl.push_back(1'b0); q_pr.push_back(96'd0);
        for (int n = 0; n < 5000; n++) begin
            bus.ce     = ($urandom_range(0, 9) != 0);
            bus.a      = 8'($urandom);
            bus.b      = 18'($urandom);
            bus.reload = ((n % 97) == 50);
            @(posedge clk); #1;
            if (bus.ce) begin
                q_rl.push_back(bus.reload);
                q_pr.push_back(ref_prod(bus.a, bus.b));
                f_rl = q_rl.pop_front();
                f_pr = q_pr.pop_front();
                acc_m = f_rl ? 96'd0 : acc_m + f_pr;
            end
            chk($sformatf("rand%0d", n), bus.p, acc_m);
        end

        // Force a known nonzero value, then check the clear is asynchronous.
        bus.ce = 1'b1; bus.a = 8'd10; bus.b = 18'd10; bus.reload = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_async_nonzero", {95'd0, (bus.p != 96'd0)}, 96'd1);
        #2 rst = 1'b0;
        #1 chk("async_reset", bus.p, 96'd0);
        @(posedge clk); #1;
        chk("reset_hold_clk", bus.p, 96'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
